u_scfifo: RTL
=============

// Module: u_scfifo
// PURPOSE
//  Parametrised single-clock FIFO; successor to the dual-clock FIFO wrapper for same-domain buffering.
//  Adds selectable showahead/normal read mode, programmable almost-full/almost-empty thresholds,
//  full-range usedw, sync clear, sticky overflow/underflow with clear, optional parity check.
//  Sits between same-clock producer/consumer stages in datapath and stream-rate adaptation logic.
// PARAMETERS
//  LPM_WIDTH          32     data word width (1..1024)
//  LPM_NUM_WORDS      256    depth; power of 2, >=4
//  LPM_WIDTHU         $clog2(LPM_NUM_WORDS)+1   usedw width; represents 0..LPM_NUM_WORDS inclusive
//  LPM_SHOWAHEAD      "ON"   "ON": q shows head word while !empty; "OFF": q loads on accepted read
//  ALMOST_FULL_VALUE  LPM_NUM_WORDS-4   almost_full threshold (1..LPM_NUM_WORDS)
//  ALMOST_EMPTY_VALUE 4      almost_empty threshold (1..LPM_NUM_WORDS)
//  OVERFLOW_CHECKING  "ON"   "ON": overflow sticky flag enabled; "OFF": overflow held 0
//  UNDERFLOW_CHECKING "ON"   "ON": underflow sticky flag enabled; "OFF": underflow held 0
// PORTS
//  clock        in   1            single clock, rising edge
//  aclr_n       in   1            asynchronous active-low reset
//  sclr         in   1            synchronous clear, priority over wrreq/rdreq
//  data         in   LPM_WIDTH    write data
//  wrreq        in   1            write request
//  rdreq        in   1            read request (ack in showahead mode)
//  q            out  LPM_WIDTH    read data
//  empty        out  1            no words stored
//  full         out  1            LPM_NUM_WORDS words stored
//  almost_empty out  1            usedw < ALMOST_EMPTY_VALUE
//  almost_full  out  1            usedw >= ALMOST_FULL_VALUE
//  usedw        out  LPM_WIDTHU   words stored
//  overflow     out  1            sticky: write attempted while full and not accepted
//  underflow    out  1            sticky: read attempted while empty
//  clr_err      in   1            clears overflow/underflow
//  parity_err   out  1            one-cycle pulse, parity mismatch on accepted read
// BEHAVIOUR
//  - Reset (aclr_n=0, immediate) and sclr (next edge): rd/wr ptr=0, usedw=0, empty=1, full=0,
//    almost_empty=1, almost_full=0, q=0, overflow=0, underflow=0, parity_err=0.
//  - rd_acc = rdreq & !empty; wr_acc = wrreq & (!full | rd_acc). Rejected requests change no state.
//  - Full + wrreq + rdreq: both accepted, usedw unchanged, no overflow.
//  - Empty + wrreq + rdreq: write accepted, read rejected, usedw->1, underflow set. No empty bypass.
//  - usedw += wr_acc - rd_acc at the edge. All flags are registered from next-usedw, so they are
//    valid in the same cycle as the updated usedw: write into empty -> empty=0 the next cycle.
//  - Pointers are LPM_WIDTHU-1 bits and wrap naturally at LPM_NUM_WORDS; no gap at the wrap.
//  - Showahead ON: storage is a register array with combinational read; q=mem[rd_ptr].
//    q is valid whenever empty=0 (1 cycle after the first write). An accepted read advances to the next word.
//    When empty=1, q holds the last head value and is don't-care to consumers.
//  - Showahead OFF: q is registered; it loads mem[rd_ptr] at the edge of rd_acc (1-cycle read latency).
//    q holds its value otherwise.
//  - overflow: set when wrreq & full & !rd_acc. underflow: set when rdreq & empty.
//    Both are sticky until clr_err, sclr or reset. A set event in the same cycle as clr_err wins.
//  - sclr in the same cycle as wrreq/rdreq: clear wins, nothing is stored.
// CONFIGURATION
//  Macro U_SCFIFO_PARITY_EN:
//   defined   - each stored word carries an extra bit = ^data. On rd_acc the stored bit is
//               compared to ^word read. A mismatch pulses parity_err high for 1 cycle.
//               In OFF mode the pulse aligns with q update; in ON mode it is the cycle after rd_acc.
//   undefined - no parity storage; parity_err tied 0; port kept for interface stability.
// TESTING
//  1 Reset/fill: after reset write 1..256 on consecutive clocks -> usedw=256, full=1, almost_full
//    from usedw=252, empty=0 from the 2nd cycle.
//  2 Drain, ON mode: read 256 words -> q sequence 1..256 with no gaps, empty=1 after the last read,
//    almost_empty=1 at usedw=3.
//  3 Drain, OFF mode: same data -> each q appears the cycle after its rdreq; q holds 256 after empty.
//  4 Boundaries: write at full -> overflow=1, usedw=256; wrreq+rdreq at full -> usedw stays 256;
//    rdreq at empty -> underflow=1; clr_err -> both flags 0.
//  5 Wrap and clear: 3 fill/drain rounds of 200 words with random gaps -> data matches a scoreboard.
//    sclr mid-stream -> usedw=0, empty=1 next cycle. aclr_n pulse mid-write -> all outputs at reset values immediately.
//  6 Parity (macro on): force one stored bit flip of word 5 -> parity_err single pulse on reading word 5,
//    no other pulses.

Source files
------------

// File: rtl/u_scfifo_if.sv
// -----------------------------------------------------------------------------
// u_scfifo_if
// Bundles the request/data/status signals of the single-clock FIFO so that
// producer/consumer logic and the FIFO connect through one port.
//   master modport : producer/consumer side (drives data, wrreq, rdreq, sclr, clr_err)
//   slave modport  : FIFO side (drives q, flags, usedw, sticky errors, parity_err)
// Parameters:
//   WIDTH  - data word width
//   WIDTHU - usedw width (must cover 0..depth inclusive)
// -----------------------------------------------------------------------------
interface u_scfifo_if #(
    parameter int WIDTH  = 32,
    parameter int WIDTHU = 9
);
    logic              sclr;
    logic [WIDTH-1:0]  data;
    logic              wrreq;
    logic              rdreq;
    logic              clr_err;
    logic [WIDTH-1:0]  q;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [WIDTHU-1:0] usedw;
    logic              overflow;
    logic              underflow;
    logic              parity_err;

    modport master (
        output sclr, data, wrreq, rdreq, clr_err,
        input  q, empty, full, almost_empty, almost_full, usedw,
               overflow, underflow, parity_err
    );

    modport slave (
        input  sclr, data, wrreq, rdreq, clr_err,
        output q, empty, full, almost_empty, almost_full, usedw,
               overflow, underflow, parity_err
    );
endinterface

// File: rtl/u_scfifo.sv
// -----------------------------------------------------------------------------
// u_scfifo
// Parametrised single-clock FIFO with showahead/normal read mode, registered
// full/empty/almost flags derived from the next occupancy, full-range usedw,
// synchronous clear, sticky overflow/underflow and optional per-word parity.
// Ports:
//   clock  - rising-edge clock
//   aclr_n - asynchronous active-low reset
//   bus    - u_scfifo_if.slave: sclr, data, wrreq, rdreq, clr_err in;
//            q, empty, full, almost_empty, almost_full, usedw, overflow,
//            underflow, parity_err out
// Configuration macro:
//   U_SCFIFO_PARITY_EN - when defined, each word stores ^data alongside it and
//   parity_err pulses for one cycle after a read whose stored bit mismatches.
//   When undefined parity_err is held 0.
// -----------------------------------------------------------------------------
module u_scfifo #(
    parameter int    LPM_WIDTH          = 32,
    parameter int    LPM_NUM_WORDS      = 256,
    parameter int    LPM_WIDTHU         = $clog2(LPM_NUM_WORDS) + 1,
    parameter string LPM_SHOWAHEAD      = "ON",
    parameter int    ALMOST_FULL_VALUE  = LPM_NUM_WORDS - 4,
    parameter int    ALMOST_EMPTY_VALUE = 4,
    parameter string OVERFLOW_CHECKING  = "ON",
    parameter string UNDERFLOW_CHECKING = "ON"
) (
    input  logic       clock,
    input  logic       aclr_n,
    u_scfifo_if.slave  bus
);
    localparam int AW = LPM_WIDTHU - 1;
`ifdef U_SCFIFO_PARITY_EN
    localparam int MW = LPM_WIDTH + 1;
`else
    localparam int MW = LPM_WIDTH;
`endif
    localparam bit SHOW_AHEAD_C = (LPM_SHOWAHEAD == "ON");
    localparam bit OVF_EN_C     = (OVERFLOW_CHECKING == "ON");
    localparam bit UDF_EN_C     = (UNDERFLOW_CHECKING == "ON");
    localparam logic [LPM_WIDTHU-1:0] FULL_CNT_C = LPM_WIDTHU'(LPM_NUM_WORDS);
    localparam logic [LPM_WIDTHU-1:0] AF_CNT_C   = LPM_WIDTHU'(ALMOST_FULL_VALUE);
    localparam logic [LPM_WIDTHU-1:0] AE_CNT_C   = LPM_WIDTHU'(ALMOST_EMPTY_VALUE);

`ifdef U_SCFIFO_PARITY_EN
    function automatic logic par_f(input logic [LPM_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    logic [MW-1:0]         mem_r [LPM_NUM_WORDS];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [LPM_WIDTHU-1:0] usedw_r;
    logic [LPM_WIDTHU-1:0] usedw_nxt_s;
    logic                  empty_r;
    logic                  full_r;
    logic                  aempty_r;
    logic                  afull_r;
    logic                  ovf_r;
    logic                  udf_r;
    logic                  par_err_r;
    logic [LPM_WIDTH-1:0]  q_r;
    logic [MW-1:0]         head_s;
    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  ovf_set_s;
    logic                  udf_set_s;

    // Accept logic, next occupancy and error-event detection
    always_comb begin
        rd_acc_s    = bus.rdreq & ~empty_r;
        // A read in the same cycle frees a slot, so a full FIFO still accepts the write
        wr_acc_s    = bus.wrreq & (~full_r | rd_acc_s);
        ovf_set_s   = bus.wrreq & full_r & ~rd_acc_s;
        udf_set_s   = bus.rdreq & empty_r;
        head_s      = mem_r[rd_ptr_r];
        usedw_nxt_s = usedw_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   usedw_nxt_s = usedw_r + LPM_WIDTHU'(1);
            2'b01:   usedw_nxt_s = usedw_r - LPM_WIDTHU'(1);
            default: usedw_nxt_s = usedw_r;
        endcase
    end

    // Word storage; no reset so it maps onto plain register storage
    always_ff @(posedge clock) begin
        if (wr_acc_s && !bus.sclr && aclr_n) begin
`ifdef U_SCFIFO_PARITY_EN
            mem_r[wr_ptr_r] <= {par_f(bus.data), bus.data};
`else
            mem_r[wr_ptr_r] <= bus.data;
`endif
        end
    end

    // Pointers, occupancy and flags; flags come from next occupancy so they track usedw
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            usedw_r  <= LPM_WIDTHU'(0);
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            aempty_r <= 1'b1;
            afull_r  <= 1'b0;
        end else if (bus.sclr) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            usedw_r  <= LPM_WIDTHU'(0);
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            aempty_r <= 1'b1;
            afull_r  <= 1'b0;
        end else begin
            // Pointers are log2(depth) bits wide so they wrap with no gap
            wr_ptr_r <= wr_acc_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
            rd_ptr_r <= rd_acc_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
            usedw_r  <= usedw_nxt_s;
            empty_r  <= (usedw_nxt_s == LPM_WIDTHU'(0));
            full_r   <= (usedw_nxt_s == FULL_CNT_C);
            aempty_r <= (usedw_nxt_s <  AE_CNT_C);
            afull_r  <= (usedw_nxt_s >= AF_CNT_C);
        end
    end

    // Sticky error flags; a new event outranks clr_err in the same cycle
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else if (bus.sclr) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (ovf_set_s && OVF_EN_C) begin
                ovf_r <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (udf_set_s && UDF_EN_C) begin
                udf_r <= 1'b1;
            end else if (bus.clr_err) begin
                udf_r <= 1'b0;
            end else begin
                udf_r <= udf_r;
            end
        end
    end

    // Read register: normal-mode q, and in showahead mode the last head shown while empty
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            q_r <= LPM_WIDTH'(0);
        end else if (bus.sclr) begin
            q_r <= LPM_WIDTH'(0);
        end else if (rd_acc_s) begin
            q_r <= head_s[LPM_WIDTH-1:0];
        end else begin
            q_r <= q_r;
        end
    end

    // Parity check pulse registered on the read edge
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            par_err_r <= 1'b0;
        end else if (bus.sclr) begin
            par_err_r <= 1'b0;
        end else begin
`ifdef U_SCFIFO_PARITY_EN
            par_err_r <= rd_acc_s & (head_s[LPM_WIDTH] != par_f(head_s[LPM_WIDTH-1:0]));
`else
            par_err_r <= 1'b0;
`endif
        end
    end

    generate
        if (SHOW_AHEAD_C) begin : g_showahead
            // Head word straight from storage; hold the last read head once drained
            assign bus.q = empty_r ? q_r : head_s[LPM_WIDTH-1:0];
        end else begin : g_normal
            assign bus.q = q_r;
        end
    endgenerate

    assign bus.empty        = empty_r;
    assign bus.full         = full_r;
    assign bus.almost_empty = aempty_r;
    assign bus.almost_full  = afull_r;
    assign bus.usedw        = usedw_r;
    assign bus.overflow     = ovf_r;
    assign bus.underflow    = udf_r;
    assign bus.parity_err   = par_err_r;
endmodule
